// File: rtl/monty_wordred_seq_if.sv
// Handshake and datapath bus for the Montgomery word-reduction sequencer.
// slave: the sequencer side; master: the product source, result consumer and datapath.
interface monty_wordred_seq_if #(
   parameter int K     = 120,
   parameter int R     = 34
);
   // valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
   // valid, once raised, is held with its data stable until that edge.
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] in_c;
   logic         out_valid;
   logic         out_ready;
   logic [K-1:0] out_t;
   logic [K-1:0] dp_c;
   logic [K-R-1:0] dp_t;

   modport slave (
      input  in_valid, in_c, out_ready, dp_t,
      output in_ready, out_valid, out_t, dp_c
   );

   modport master (
      output in_valid, in_c, out_ready, dp_t,
      input  in_ready, out_valid, out_t, dp_c
   );
endinterface

// File: rtl/monty_wordred_seq.sv
// Iterative sequencer running NWORD passes of a shared Montgomery word-reduction datapath.
// Optional final conditional subtraction of q is built when MONTY_WORDRED_SEQ_FINALSUB_EN is defined.
module monty_wordred_seq #(
   parameter int K     = 120,
   parameter int Q_LEN = 60,
   parameter int R     = 34,
   parameter int NWORD = 2,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Q_LEN-1:0] q,
   output logic             busy,
   output logic [2:0]       dbg_state,
   monty_wordred_seq_if.slave bus
);
   localparam int PW = $clog2(NWORD + 1);
   localparam int LW = $clog2(LAT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
`ifdef MONTY_WORDRED_SEQ_FINALSUB_EN
      SUB   = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

   state_t         state;
   logic [K-1:0]   work;
   logic [PW-1:0]  pass;
   logic [LW-1:0]  lat;
   logic           in_ready_r;
   logic           out_valid_r;
   logic           busy_r;

`ifdef MONTY_WORDRED_SEQ_FINALSUB_EN
   logic [K-1:0]   q_ext;
   assign q_ext = {{(K-Q_LEN){1'b0}}, q};
`else
   logic           q_unused;
   assign q_unused = ^q;
`endif

   assign bus.dp_c      = work;
   assign bus.out_t     = work;
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign busy          = busy_r;
   assign dbg_state     = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         work        <= '0;
         pass        <= '0;
         lat         <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               // in_ready_r stays low for the first cycle after reset release
               if (bus.in_valid && in_ready_r) begin
                  work       <= bus.in_c;
                  pass       <= '0;
                  state      <= ISSUE;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ISSUE: begin
               lat   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               lat <= lat + LW'(1);
               if (lat == LW'(LAT - 1)) begin
                  work <= {{R{1'b0}}, bus.dp_t};
                  pass <= pass + PW'(1);
                  lat  <= '0;
                  if (pass == PW'(NWORD - 1)) begin
`ifdef MONTY_WORDRED_SEQ_FINALSUB_EN
                     state <= SUB;
`else
                     state       <= DONE;
                     out_valid_r <= 1'b1;
`endif
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
`ifdef MONTY_WORDRED_SEQ_FINALSUB_EN
            SUB: begin
               if (work >= q_ext) work <= work - q_ext;
               state       <= DONE;
               out_valid_r <= 1'b1;
            end
`endif
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule
